// File: rtl/rnn_in_feeder.sv
// -----------------------------------------------------------------------------
// rnn_in_feeder
//
// Bit-serial stimulus source for the RNN top level. The host pushes one 3-bit
// frame per RNN timestep into an internal FIFO (bit k belongs to input k).
// Each of the three channels serves its bit of the head frame over a
// REQ/ACK/DATA handshake. The head frame is retired only after all three
// channels have consumed it, so the inputs stay aligned in time.
//
// Parameters:
//   DEPTH            FIFO depth in frames (power of two, >= 2)
//
// Ports:
//   CLK              clock, all state on the rising edge
//   RSTB             asynchronous reset, active high
//   WR_VALID         host frame valid
//   WR_READY         FIFO can accept a frame (combinational from the count)
//   WR_DATA[2:0]     frame, bit k feeds channel k
//   INk_REQ          consumer request from the RNN (k = 0..2)
//   INk_ACK          registered one-cycle data-valid strobe to the RNN
//   INk_DATA         registered serial data bit, 0 whenever INk_ACK is 0
//   LEVEL            frames currently stored
//   FRAME_CNT[15:0]  frames retired, wrapping; present only when the macro
//                    RNN_FEEDER_STATS_EN is defined
// -----------------------------------------------------------------------------
module rnn_in_feeder #(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RSTB,
    input  logic                     WR_VALID,
    output logic                     WR_READY,
    input  logic [2:0]               WR_DATA,
    input  logic                     IN0_REQ,
    input  logic                     IN1_REQ,
    input  logic                     IN2_REQ,
    output logic                     IN0_ACK,
    output logic                     IN1_ACK,
    output logic                     IN2_ACK,
    output logic                     IN0_DATA,
    output logic                     IN1_DATA,
    output logic                     IN2_DATA,
    output logic [$clog2(DEPTH):0]   LEVEL
`ifdef RNN_FEEDER_STATS_EN
    ,
    output logic [15:0]              FRAME_CNT
`endif
);

    localparam int AW = $clog2(DEPTH);
    // DEPTH is a power of two, so "full" is a single MSB set in the count.
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } ch_state_t;

    // FIFO storage and bookkeeping
    logic [2:0]    mem_q [DEPTH];
    logic [2:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Per-channel handshake state
    ch_state_t     state_q [3];
    ch_state_t     state_d [3];
    logic [2:0]    ack_q, ack_d;
    logic [2:0]    data_q, data_d;
    logic [2:0]    done_q, done_d;

    logic [2:0]    req_s;
    logic [2:0]    head_s;
    logic [2:0]    serve_s;
    logic [2:0]    done_set_s;
    logic          empty_s;
    logic          wr_en_s;
    logic          pop_s;

`ifdef RNN_FEEDER_STATS_EN
    logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

    assign req_s    = {IN2_REQ, IN1_REQ, IN0_REQ};
    assign head_s   = mem_q[rd_ptr_q];
    assign empty_s  = (count_q == {(AW+1){1'b0}});
    // No write-through: a full FIFO refuses a write even if a pop happens
    // on the same edge.
    assign WR_READY = (count_q != FULL_LVL);
    assign wr_en_s  = WR_VALID && WR_READY;

    assign IN0_ACK  = ack_q[0];
    assign IN1_ACK  = ack_q[1];
    assign IN2_ACK  = ack_q[2];
    assign IN0_DATA = data_q[0];
    assign IN1_DATA = data_q[1];
    assign IN2_DATA = data_q[2];
    assign LEVEL    = count_q;

    // Channel FSM next-state: serve a bit from IDLE, strobe one cycle, then wait for REQ low
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            state_d[k] = state_q[k];
            ack_d[k]   = 1'b0;
            data_d[k]  = 1'b0;
            serve_s[k] = 1'b0;
            case (state_q[k])
                ST_IDLE: begin
                    if (req_s[k] && !empty_s && !done_q[k]) begin
                        state_d[k] = ST_ACK;
                        ack_d[k]   = 1'b1;
                        data_d[k]  = head_s[k];
                        serve_s[k] = 1'b1;
                    end else begin
                        state_d[k] = ST_IDLE;
                    end
                end
                ST_ACK: begin
                    state_d[k] = ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!req_s[k]) begin
                        state_d[k] = ST_IDLE;
                    end else begin
                        state_d[k] = ST_WAIT_LOW;
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                end
            endcase
        end
    end

    // Done-flags and pop: a channel is marked done on the edge its ACK rises;
    // the frame retires on the edge where the last flag gets set.
    always_comb begin
        done_set_s = done_q | serve_s;
        pop_s      = &done_set_s;
        if (pop_s) begin
            done_d = 3'b000;
        end else begin
            done_d = done_set_s;
        end
    end

    // FIFO next-state: storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = WR_DATA;
            wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

`ifdef RNN_FEEDER_STATS_EN
    // Retired-frame counter next-state, wraps naturally at 16 bits
    always_comb begin
        if (pop_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Retired-frame counter register
    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign FRAME_CNT = frame_cnt_q;
`endif

    // FIFO state registers; reset flushes contents so no stale frame survives
    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'b000;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Channel state registers; reset drops any in-flight ACK immediately
    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= ST_IDLE;
            end
            ack_q  <= 3'b000;
            data_q <= 3'b000;
            done_q <= 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                state_q[k] <= state_d[k];
            end
            ack_q  <= ack_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

endmodule
